// File: rtl/vga_sync_gen.sv
// VGA timing stage: free-running H/V scan counters drive the pixel address out,
// returned colour and sync pulses are re-aligned through a matching delay line.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE  = 800,
    parameter int unsigned H_FRONT    = 56,
    parameter int unsigned H_SYNC     = 120,
    parameter int unsigned H_BACK     = 64,
    parameter int unsigned V_VISIBLE  = 600,
    parameter int unsigned V_FRONT    = 37,
    parameter int unsigned V_SYNC     = 6,
    parameter int unsigned V_BACK     = 23,
    parameter logic        SYNC_POL   = 1'b1,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic        sysclk,
    input  logic        reset_n,
    output logic [19:0] display_addr,
    output logic        display_active,
    output logic        frame_start,
    input  logic [2:0]  display_data,
    output logic [2:0]  vga_rgb,
    output logic        vga_hsync,
    output logic        vga_vsync
);

    localparam int unsigned HW      = 11;
    localparam int unsigned VW      = 10;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS     = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_LO = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_HI = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS     = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_LO = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_HI = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_active;
    logic          w_hs_raw;
    logic          w_vs_raw;
    // Delay-line stage bundle: {active, hs_raw, vs_raw}
    logic [2:0]    r_pipe [PIPE_DELAY];
    logic [2:0]    w_pipe_out;

    // Scan counters: h every clock, v on each h wrap
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    // Scan-position decode straight from the counter flops
    assign w_active       = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign w_hs_raw       = (r_h_cnt >= H_SYNC_LO) && (r_h_cnt < H_SYNC_HI);
    assign w_vs_raw       = (r_v_cnt >= V_SYNC_LO) && (r_v_cnt < V_SYNC_HI);
    assign display_active = w_active;
    assign display_addr   = w_active ? {r_h_cnt[9:0], r_v_cnt} : 20'd0;
    assign frame_start    = (r_h_cnt == '0) && (r_v_cnt == '0);

    // First delay stage captures the live decode
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            r_pipe[0] <= '0;
        end else begin
            r_pipe[0] <= {w_active, w_hs_raw, w_vs_raw};
        end
    end

    // Remaining stages match the downstream pixel-fetch latency
    for (genvar g = 1; g < PIPE_DELAY; g++) begin : g_pipe
        always_ff @(posedge sysclk) begin
            if (!reset_n) begin
                r_pipe[g] <= '0;
            end else begin
                r_pipe[g] <= r_pipe[g-1];
            end
        end
    end

    assign w_pipe_out = r_pipe[PIPE_DELAY-1];

    // Output register: colour gated by delayed active, syncs at configured polarity
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            vga_rgb   <= 3'd0;
            vga_hsync <= ~SYNC_POL;
            vga_vsync <= ~SYNC_POL;
        end else begin
            vga_rgb   <= w_pipe_out[2] ? display_data : 3'd0;
            vga_hsync <= w_pipe_out[1] ? SYNC_POL : ~SYNC_POL;
            vga_vsync <= w_pipe_out[0] ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: a shrunken-timing instance for frame-level behaviour and a
// default-timing instance for real 800x600 hsync placement.
module tb_vga_sync_gen;

    logic        clk;
    logic        reset_n;

    logic [19:0] s_addr;
    logic        s_active;
    logic        s_fs;
    logic [2:0]  s_data;
    logic [2:0]  s_rgb;
    logic        s_hs;
    logic        s_vs;

    logic [19:0] d_addr;
    logic        d_active;
    logic        d_fs;
    logic [2:0]  d_data;
    logic [2:0]  d_rgb;
    logic        d_hs;
    logic        d_vs;

    int n_cmp;
    int n_mis;
    int k;

    // Small timing: H_TOTAL=15 (vis 8, sync [10,13)), V_TOTAL=8 (vis 4, sync [5,7))
    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_POL(1'b1), .PIPE_DELAY(2)
    ) dut_s (
        .sysclk(clk), .reset_n(reset_n),
        .display_addr(s_addr), .display_active(s_active), .frame_start(s_fs),
        .display_data(s_data), .vga_rgb(s_rgb),
        .vga_hsync(s_hs), .vga_vsync(s_vs)
    );

    vga_sync_gen dut_d (
        .sysclk(clk), .reset_n(reset_n),
        .display_addr(d_addr), .display_active(d_active), .frame_start(d_fs),
        .display_data(d_data), .vga_rgb(d_rgb),
        .vga_hsync(d_hs), .vga_vsync(d_vs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to count edge 'target' (edges numbered from reset release), sample 1ns later
    task automatic run_to(input int target);
        while (k < target) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_mis   = 0;
        k       = 0;
        reset_n = 1'b0;
        s_data  = 3'b101;
        d_data  = 3'b000;

        // Held in reset
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("rst_rgb",    32'(s_rgb),    32'd0);
        check("rst_hs",     32'(s_hs),     32'd0);
        check("rst_vs",     32'(s_vs),     32'd0);
        check("rst_addr",   32'(s_addr),   32'd0);
        check("rst_active", 32'(s_active), 32'd1);
        check("rst_fs",     32'(s_fs),     32'd1);
        check("rst_d_hs",   32'(d_hs),     32'd0);
        check("rst_d_vs",   32'(d_vs),     32'd0);

        reset_n = 1'b1;

        // First line of the small instance
        run_to(1);
        check("addr_h1",    32'(s_addr),   32'h00400);
        check("active_h1",  32'(s_active), 32'd1);
        check("fs_h1",      32'(s_fs),     32'd0);
        run_to(2);
        check("rgb_k2",     32'(s_rgb),    32'd0);
        run_to(3);
        check("rgb_k3",     32'(s_rgb),    32'd5);
        run_to(7);
        check("addr_h7",    32'(s_addr),   32'h01C00);
        run_to(8);
        check("addr_h8",    32'(s_addr),   32'd0);
        check("active_h8",  32'(s_active), 32'd0);
        run_to(10);
        check("rgb_k10",    32'(s_rgb),    32'd5);
        run_to(11);
        check("rgb_k11",    32'(s_rgb),    32'd0);
        run_to(12);
        check("hs_k12",     32'(s_hs),     32'd0);
        run_to(13);
        check("hs_k13",     32'(s_hs),     32'd1);
        run_to(14);
        check("addr_h14",   32'(s_addr),   32'd0);
        run_to(15);
        check("hs_k15",     32'(s_hs),     32'd1);
        check("addr_wrap",  32'(s_addr),   32'h00001);
        check("active_wrap",32'(s_active), 32'd1);
        run_to(16);
        check("hs_k16",     32'(s_hs),     32'd0);
        run_to(28);
        check("hs_k28",     32'(s_hs),     32'd1);

        // Last visible pixel and the blanking that follows
        run_to(52);
        check("addr_last",  32'(s_addr),   32'h01C03);
        check("active_last",32'(s_active), 32'd1);
        run_to(53);
        check("addr_after", 32'(s_addr),   32'd0);
        run_to(60);
        check("active_v4",  32'(s_active), 32'd0);
        check("addr_v4",    32'(s_addr),   32'd0);

        // Vertical sync window: lines 5..6, delayed three clocks
        run_to(77);
        check("vs_k77",     32'(s_vs),     32'd0);
        run_to(78);
        check("vs_k78",     32'(s_vs),     32'd1);
        run_to(107);
        check("vs_k107",    32'(s_vs),     32'd1);
        run_to(108);
        check("vs_k108",    32'(s_vs),     32'd0);

        // Frame start pulse at frame boundary
        run_to(119);
        check("fs_k119",    32'(s_fs),     32'd0);
        run_to(120);
        check("fs_k120",    32'(s_fs),     32'd1);

        // Second frame swept clock by clock against scan-position arithmetic
        for (int kk = 121; kk < 240; kk++) begin
            int p;
            int ph;
            int pv;
            run_to(kk);
            p  = kk - 3;
            ph = p % 15;
            pv = (p / 15) % 8;
            check($sformatf("sweep_rgb_%0d", kk), 32'(s_rgb),
                  (ph < 8 && pv < 4) ? 32'd5 : 32'd0);
            check($sformatf("sweep_hs_%0d", kk), 32'(s_hs),
                  (ph >= 10 && ph < 13) ? 32'd1 : 32'd0);
            check($sformatf("sweep_vs_%0d", kk), 32'(s_vs),
                  (pv >= 5 && pv < 7) ? 32'd1 : 32'd0);
            check($sformatf("sweep_fs_%0d", kk), 32'(s_fs), 32'd0);
        end
        run_to(240);
        check("fs_k240",    32'(s_fs),     32'd1);

        // Default 800x600 timing: hsync high for count edges [859,979), period 1040
        run_to(858);
        check("d_hs_858",   32'(d_hs),     32'd0);
        run_to(859);
        check("d_hs_859",   32'(d_hs),     32'd1);
        run_to(978);
        check("d_hs_978",   32'(d_hs),     32'd1);
        run_to(979);
        check("d_hs_979",   32'(d_hs),     32'd0);
        run_to(1898);
        check("d_hs_1898",  32'(d_hs),     32'd0);
        run_to(1899);
        check("d_hs_1899",  32'(d_hs),     32'd1);

        // One-clock reset while the small instance's delay line holds an hsync
        run_to(1902);
        reset_n = 1'b0;
        run_to(1903);
        check("mid_rgb",    32'(s_rgb),    32'd0);
        check("mid_hs",     32'(s_hs),     32'd0);
        check("mid_addr",   32'(s_addr),   32'd0);
        check("mid_active", 32'(s_active), 32'd1);
        check("mid_fs",     32'(s_fs),     32'd1);
        check("mid_d_hs",   32'(d_hs),     32'd0);
        reset_n = 1'b1;
        run_to(1904);
        check("post_hs1",   32'(s_hs),     32'd0);
        check("post_rgb1",  32'(s_rgb),    32'd0);
        check("post_addr1", 32'(s_addr),   32'h00400);
        run_to(1905);
        check("post_hs2",   32'(s_hs),     32'd0);
        check("post_rgb2",  32'(s_rgb),    32'd0);
        run_to(1906);
        check("post_rgb3",  32'(s_rgb),    32'd5);
        run_to(1916);
        check("post_hs13",  32'(s_hs),     32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
